// File: rtl/sample_playback_tx.sv
// rtl/sample_playback_tx.sv - replays host-loaded IF samples as clk_sample / sample_valid / data
// Show-ahead sample FIFO, divided sample-clock generator and playback state machine.
module sample_playback_tx #(
    parameter int CLK_DIV     = 8,
    parameter int DEPTH_LOG2  = 4,
    parameter int PRIME_LEVEL = 4,
    parameter int DATA_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    output logic                  full_o,
    output logic [DEPTH_LOG2:0]   fifo_level_o,
    output logic                  overflow_o,
    output logic [15:0]           underflow_count_o,
    output logic                  running_o,
    output logic                  clk_sample_o,
    output logic                  sample_valid_o,
    output logic [DATA_W-1:0]     data_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PH_W  = $clog2(CLK_DIV);
    localparam int LVL_W = DEPTH_LOG2 + 1;
    localparam logic [PH_W-1:0]  PH_HALF_M1 = PH_W'(CLK_DIV / 2 - 1);
    localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_PRIME  = LVL_W'(PRIME_LEVEL);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  full_q, overflow_q;

    state_t                state_q;
    logic [PH_W-1:0]       ph_q;
    logic                  drain_q;
    logic                  clk_sample_q, sample_valid_q, running_q;
    logic [DATA_W-1:0]     data_q;
    logic [15:0]           underflow_q;

    logic fall_edge, draining, empty, push, pop;
    logic [DATA_W-1:0] head;

    assign empty     = (level_q == '0);
    assign head      = mem[rd_ptr_q];
    assign fall_edge = (state_q == RUN) && (ph_q == PH_HALF_M1);
    // Once enable drops in RUN the rest of the period is a drain: no pops, no underflow.
    assign draining  = drain_q || !enable_i;
    assign pop       = fall_edge && !draining && !empty;
    assign push      = wr_en_i && !full_q && !flush_i;

    always_comb begin
        level_d = level_q;
        if (push && !pop) level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
            full_q  <= (level_d == LVL_FULL);
            if (wr_en_i && full_q) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q        <= IDLE;
            ph_q           <= '0;
            drain_q        <= 1'b0;
            clk_sample_q   <= 1'b0;
            sample_valid_q <= 1'b0;
            running_q      <= 1'b0;
            data_q         <= '0;
            underflow_q    <= '0;
        end else begin
            if (flush_i) underflow_q <= '0;
            case (state_q)
                IDLE: begin
                    ph_q           <= '0;
                    drain_q        <= 1'b0;
                    clk_sample_q   <= 1'b0;
                    sample_valid_q <= 1'b0;
                    running_q      <= 1'b0;
                    if (enable_i) state_q <= PRIME;
                end
                PRIME: begin
                    clk_sample_q <= 1'b0;
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (level_q >= LVL_PRIME) begin
                        state_q      <= RUN;
                        ph_q         <= '0;
                        clk_sample_q <= 1'b1;
                        running_q    <= 1'b1;
                    end
                end
                RUN: begin
                    if (!enable_i) drain_q <= 1'b1;
                    if (ph_q == PH_LAST) begin
                        ph_q <= '0;
                        if (draining) begin
                            state_q        <= IDLE;
                            clk_sample_q   <= 1'b0;
                            sample_valid_q <= 1'b0;
                            running_q      <= 1'b0;
                            drain_q        <= 1'b0;
                        end else begin
                            clk_sample_q <= 1'b1;
                        end
                    end else begin
                        ph_q         <= ph_q + 1'b1;
                        clk_sample_q <= (ph_q < PH_HALF_M1);
                        if (fall_edge) begin
                            if (draining) begin
                                sample_valid_q <= 1'b0;
                            end else if (!empty) begin
                                data_q         <= head;
                                sample_valid_q <= 1'b1;
                            end else begin
                                sample_valid_q <= 1'b0;
                                if (!flush_i && underflow_q != 16'hFFFF)
                                    underflow_q <= underflow_q + 16'd1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign full_o            = full_q;
    assign fifo_level_o      = level_q;
    assign overflow_o        = overflow_q;
    assign underflow_count_o = underflow_q;
    assign running_o         = running_q;
    assign clk_sample_o      = clk_sample_q;
    assign sample_valid_o    = sample_valid_q;
    assign data_o            = data_q;

endmodule
